// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the writeback stage: datapath width default, RISC-V load
// funct3 encodings, FSM state type and a load-legality helper.
package reg_writeback_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        StIdle,
        StWaitLoad
    } wb_state_e;

    function automatic logic is_legal_load(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/reg_writeback_load_formatter.sv
// Combinational load formatter: selects the byte/half/word addressed by addr_lo from an
// aligned memory word and sign/zero extends it; also reports misalignment and illegal funct3.
// Ports:
//   funct3   in   3     load type
//   addr_lo  in   2     byte address [1:0]
//   rdata    in   XLEN  aligned word from data memory
//   data     out  XLEN  extracted, extended load value
//   misalign out  1     LH/LHU at offset 3, or LW at a non-zero offset
//   illegal  out  1     funct3 is not a load encoding
module reg_writeback_load_formatter
    import reg_writeback_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            misalign,
    output logic            illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        half_sel = rdata[15:0];
        case (addr_lo)
            2'd1: begin
                byte_sel = rdata[15:8];
                half_sel = rdata[23:8];
            end
            2'd2: begin
                byte_sel = rdata[23:16];
                half_sel = rdata[31:16];
            end
            2'd3: begin
                byte_sel = rdata[31:24];
                // Half at offset 3 straddles words; it is flagged and never written.
                half_sel = {8'h00, rdata[31:24]};
            end
            default: begin
                byte_sel = rdata[7:0];
                half_sel = rdata[15:0];
            end
        endcase
    end

    always_comb begin
        data     = '0;
        misalign = 1'b0;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data     = {{(XLEN-16){half_sel[15]}}, half_sel};
                misalign = (addr_lo == 2'd3);
            end
            F3_LHU: begin
                data     = {{(XLEN-16){1'b0}}, half_sel};
                misalign = (addr_lo == 2'd3);
            end
            F3_LW: begin
                data     = rdata;
                misalign = (addr_lo != 2'd0);
            end
            default: data = '0;
        endcase
    end

    assign illegal = !is_legal_load(funct3);

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage, sole writer of the register file. ALU results are written one cycle after
// transfer; loads wait for the data-memory response, then are formatted and written. Misaligned
// and illegal loads are rejected at accept; a missing response aborts after LOAD_TIMEOUT cycles.
// Optional feature macro: WB_BYPASS_EN adds byp_valid/byp_rd/byp_data mirroring the write port.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready handshake; in_wen, in_is_load, in_rd, in_funct3, in_addr_lo, in_result
//   mem_rsp_valid, mem_rdata  load response
//   rf_w_enb, rf_rd, rf_w_data  register-file write port (registered)
//   busy  waiting for a load response
//   err_misalign, err_funct3, err_timeout  one-cycle error pulses (registered)
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int unsigned XLEN         = XLEN_DEFAULT,
    parameter int unsigned LOAD_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_wen,
    input  logic            in_is_load,
    input  logic [4:0]      in_rd,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_result,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rf_w_enb,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_w_data,
    output logic            busy,
    output logic            err_misalign,
    output logic            err_funct3,
    output logic            err_timeout
`ifdef WB_BYPASS_EN
    ,
    output logic            byp_valid,
    output logic [4:0]      byp_rd,
    output logic [XLEN-1:0] byp_data
`endif
);

    localparam int unsigned CntW = $clog2(LOAD_TIMEOUT);
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(LOAD_TIMEOUT - 1);

    wb_state_e       state_q;
    logic [CntW-1:0] cnt_q;
    logic            ld_wen_q;
    logic [4:0]      ld_rd_q;
    logic [2:0]      ld_funct3_q;
    logic [1:0]      ld_addr_q;

    logic            in_ready_q;
    logic            busy_q;
    logic            rf_w_enb_q;
    logic [4:0]      rf_rd_q;
    logic [XLEN-1:0] rf_w_data_q;
    logic            err_misalign_q;
    logic            err_funct3_q;
    logic            err_timeout_q;

    logic [2:0]      fmt_funct3;
    logic [1:0]      fmt_addr;
    logic [XLEN-1:0] fmt_data;
    logic            fmt_misalign;
    logic            fmt_illegal;
    logic            transfer;
    logic            writes_rd;

    // One formatter serves both uses: accept-time checks on the incoming instruction while
    // idle, data extraction on the captured load while waiting.
    assign fmt_funct3 = (state_q == StIdle) ? in_funct3 : ld_funct3_q;
    assign fmt_addr   = (state_q == StIdle) ? in_addr_lo : ld_addr_q;

    reg_writeback_load_formatter #(
        .XLEN (XLEN)
    ) u_fmt (
        .funct3   (fmt_funct3),
        .addr_lo  (fmt_addr),
        .rdata    (mem_rdata),
        .data     (fmt_data),
        .misalign (fmt_misalign),
        .illegal  (fmt_illegal)
    );

    assign transfer  = in_valid && in_ready_q;
    assign writes_rd = in_wen && (in_rd != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            ld_wen_q       <= 1'b0;
            ld_rd_q        <= '0;
            ld_funct3_q    <= '0;
            ld_addr_q      <= '0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            rf_w_enb_q     <= 1'b0;
            rf_rd_q        <= '0;
            rf_w_data_q    <= '0;
            err_misalign_q <= 1'b0;
            err_funct3_q   <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            // Write enable and error flags are single-cycle pulses.
            rf_w_enb_q     <= 1'b0;
            err_misalign_q <= 1'b0;
            err_funct3_q   <= 1'b0;
            err_timeout_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    if (transfer) begin
                        if (!in_is_load) begin
                            if (writes_rd) begin
                                rf_w_enb_q  <= 1'b1;
                                rf_rd_q     <= in_rd;
                                rf_w_data_q <= in_result;
                            end
                        end else if (fmt_illegal) begin
                            err_funct3_q <= 1'b1;
                        end else if (fmt_misalign) begin
                            err_misalign_q <= 1'b1;
                        end else begin
                            // Loads to x0 still wait so the response is consumed here.
                            ld_wen_q    <= writes_rd;
                            ld_rd_q     <= in_rd;
                            ld_funct3_q <= in_funct3;
                            ld_addr_q   <= in_addr_lo;
                            cnt_q       <= '0;
                            state_q     <= StWaitLoad;
                            in_ready_q  <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                StWaitLoad: begin
                    if (mem_rsp_valid) begin
                        // A response on the timeout cycle still completes the load.
                        if (ld_wen_q) begin
                            rf_w_enb_q  <= 1'b1;
                            rf_rd_q     <= ld_rd_q;
                            rf_w_data_q <= fmt_data;
                        end
                        state_q    <= StIdle;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else if (cnt_q == TimeoutCnt) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= StIdle;
                        in_ready_q    <= 1'b1;
                        busy_q        <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign rf_w_enb     = rf_w_enb_q;
    assign rf_rd        = rf_rd_q;
    assign rf_w_data    = rf_w_data_q;
    assign err_misalign = err_misalign_q;
    assign err_funct3   = err_funct3_q;
    assign err_timeout  = err_timeout_q;

`ifdef WB_BYPASS_EN
    assign byp_valid = rf_w_enb_q;
    assign byp_rd    = rf_rd_q;
    assign byp_data  = rf_w_data_q;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios followed by random traffic, all checked
// against a transaction-level reference model (pending-load record plus cycle timestamps).
module tb_reg_writeback;

    localparam int XLEN = 32;
    localparam int TMO  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_wen = 1'b0;
    logic            in_is_load = 1'b0;
    logic [4:0]      in_rd = '0;
    logic [2:0]      in_funct3 = '0;
    logic [1:0]      in_addr_lo = '0;
    logic [XLEN-1:0] in_result = '0;
    logic            mem_rsp_valid = 1'b0;
    logic [XLEN-1:0] mem_rdata = '0;
    logic            rf_w_enb;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_w_data;
    logic            busy;
    logic            err_misalign;
    logic            err_funct3;
    logic            err_timeout;
`ifdef WB_BYPASS_EN
    logic            byp_valid;
    logic [4:0]      byp_rd;
    logic [XLEN-1:0] byp_data;
`endif

    always #5 clk = ~clk;

    reg_writeback #(
        .XLEN         (XLEN),
        .LOAD_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wen        (in_wen),
        .in_is_load    (in_is_load),
        .in_rd         (in_rd),
        .in_funct3     (in_funct3),
        .in_addr_lo    (in_addr_lo),
        .in_result     (in_result),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .rf_w_enb      (rf_w_enb),
        .rf_rd         (rf_rd),
        .rf_w_data     (rf_w_data),
        .busy          (busy),
        .err_misalign  (err_misalign),
        .err_funct3    (err_funct3),
        .err_timeout   (err_timeout)
`ifdef WB_BYPASS_EN
        ,
        .byp_valid     (byp_valid),
        .byp_rd        (byp_rd),
        .byp_data      (byp_data)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: edge count, at most one outstanding load.
    int         cyc = 0;
    bit         pend = 1'b0;
    int         pend_start = 0;
    bit         pend_wr = 1'b0;
    logic [4:0] pend_rd = '0;
    logic [2:0] pend_f3 = '0;
    logic [1:0] pend_a = '0;
    bit         m_ready = 1'b0;

    logic        exp_enb, exp_mis, exp_f3, exp_tmo;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] v, b, h;
        v = w >> (32'(a) * 8);
        b = v & 32'h0000_00FF;
        h = v & 32'h0000_FFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic bit ref_illegal(input logic [2:0] f3);
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [1:0] a);
        if (f3 == 3'd2) return a != 2'd0;
        if (f3 == 3'd1 || f3 == 3'd5) return a == 2'd3;
        return 1'b0;
    endfunction

    // Predict the effect of the coming clock edge from the current inputs.
    task automatic model_edge();
        exp_enb = 1'b0; exp_mis = 1'b0; exp_f3 = 1'b0; exp_tmo = 1'b0;
        exp_rd = '0; exp_data = '0;
        cyc++;
        if (!rst) begin
            pend    = 1'b0;
            m_ready = 1'b0;
            return;
        end
        if (pend) begin
            if (mem_rsp_valid) begin
                pend = 1'b0;
                if (pend_wr) begin
                    exp_enb  = 1'b1;
                    exp_rd   = pend_rd;
                    exp_data = ref_load(pend_f3, pend_a, mem_rdata);
                end
            end else if (cyc - pend_start == TMO) begin
                pend    = 1'b0;
                exp_tmo = 1'b1;
            end
        end else if (in_valid && m_ready) begin
            if (!in_is_load) begin
                if (in_wen && in_rd != 5'd0) begin
                    exp_enb  = 1'b1;
                    exp_rd   = in_rd;
                    exp_data = in_result;
                end
            end else if (ref_illegal(in_funct3)) begin
                exp_f3 = 1'b1;
            end else if (ref_misaligned(in_funct3, in_addr_lo)) begin
                exp_mis = 1'b1;
            end else begin
                pend       = 1'b1;
                pend_start = cyc;
                pend_wr    = in_wen && (in_rd != 5'd0);
                pend_rd    = in_rd;
                pend_f3    = in_funct3;
                pend_a     = in_addr_lo;
            end
        end
        m_ready = !pend;
    endtask

    task automatic compare();
        check("in_ready", 32'(in_ready), 32'(m_ready));
        check("busy", 32'(busy), 32'(pend));
        check("rf_w_enb", 32'(rf_w_enb), 32'(exp_enb));
        check("err_misalign", 32'(err_misalign), 32'(exp_mis));
        check("err_funct3", 32'(err_funct3), 32'(exp_f3));
        check("err_timeout", 32'(err_timeout), 32'(exp_tmo));
        if (exp_enb) begin
            check("rf_rd", 32'(rf_rd), 32'(exp_rd));
            check("rf_w_data", rf_w_data, exp_data);
        end
`ifdef WB_BYPASS_EN
        check("byp_valid", 32'(byp_valid), 32'(exp_enb));
        if (exp_enb) begin
            check("byp_rd", 32'(byp_rd), 32'(exp_rd));
            check("byp_data", byp_data, exp_data);
        end
`endif
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic set_idle();
        in_valid = 1'b0; in_is_load = 1'b0; in_wen = 1'b0; mem_rsp_valid = 1'b0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] res);
        in_valid = 1'b1; in_is_load = 1'b0; in_wen = 1'b1; in_rd = rd; in_result = res;
        mem_rsp_valid = 1'b0;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a);
        in_valid = 1'b1; in_is_load = 1'b1; in_wen = 1'b1; in_rd = rd;
        in_funct3 = f3; in_addr_lo = a; mem_rsp_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b0;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_enb", 32'(rf_w_enb), 32'd0);
        check("rst_rd", 32'(rf_rd), 32'd0);
        check("rst_data", rf_w_data, 32'd0);
        check("rst_errs", {29'd0, err_misalign, err_funct3, err_timeout}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // 1: back-to-back ALU writes
        for (int i = 0; i < 3; i++) begin
            drive_alu(5'd5, 32'hDEADBEEF + 32'(i));
            tick();
            check("alu_enb", 32'(rf_w_enb), 32'd1);
            check("alu_data", rf_w_data, 32'hDEADBEEF + 32'(i));
        end
        set_idle();
        tick();

        // 2: LB / LBU at offset 2, response three cycles after accept
        for (int k = 0; k < 2; k++) begin
            drive_load(5'd7, (k == 0) ? 3'd0 : 3'd4, 2'd2);
            tick();
            set_idle();
            mem_rdata = 32'h1280_3456;
            tick();
            check("ld_wait_ready", 32'(in_ready), 32'd0);
            tick();
            mem_rsp_valid = 1'b1;
            tick();
            check("ld_enb", 32'(rf_w_enb), 32'd1);
            check("ld_data", rf_w_data, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            set_idle();
            tick();
        end

        // 3: misaligned LW, illegal funct3
        drive_load(5'd8, 3'd2, 2'd1);
        tick();
        check("misalign_pulse", 32'(err_misalign), 32'd1);
        check("misalign_ready", 32'(in_ready), 32'd1);
        drive_load(5'd8, 3'd3, 2'd0);
        tick();
        check("funct3_pulse", 32'(err_funct3), 32'd1);
        set_idle();
        tick();

        // 4: timeout after 16 cycles; response on the timeout cycle wins
        drive_load(5'd9, 3'd2, 2'd0);
        tick();
        set_idle();
        repeat (TMO - 1) tick();
        tick();
        check("timeout_pulse", 32'(err_timeout), 32'd1);
        tick();
        drive_load(5'd10, 3'd2, 2'd0);
        tick();
        set_idle();
        repeat (TMO - 1) tick();
        mem_rdata = 32'hCAFE_F00D;
        mem_rsp_valid = 1'b1;
        tick();
        check("late_rsp_enb", 32'(rf_w_enb), 32'd1);
        check("late_rsp_tmo", 32'(err_timeout), 32'd0);
        set_idle();
        tick();

        // 5: x0 destinations, reset during a load
        drive_alu(5'd0, 32'h1234_5678);
        tick();
        check("x0_alu_enb", 32'(rf_w_enb), 32'd0);
        drive_load(5'd0, 3'd2, 2'd0);
        tick();
        set_idle();
        tick();
        mem_rsp_valid = 1'b1;
        tick();
        check("x0_ld_enb", 32'(rf_w_enb), 32'd0);
        set_idle();
        drive_load(5'd3, 3'd2, 2'd0);
        tick();
        set_idle();
        tick();
        #2 rst = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b1;
        mem_rsp_valid = 1'b1;
        tick();
        check("post_rst_enb", 32'(rf_w_enb), 32'd0);
        set_idle();
        tick();

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            in_valid      = 1'($urandom_range(0, 1));
            in_is_load    = ($urandom_range(0, 2) == 0);
            in_wen        = ($urandom_range(0, 3) != 0);
            in_rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            in_funct3     = 3'($urandom_range(0, 7));
            in_addr_lo    = 2'($urandom_range(0, 3));
            in_result     = $urandom;
            mem_rdata     = $urandom;
            mem_rsp_valid = ($urandom_range(0, 9) == 0);
            tick();
        end
        set_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
